fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: word width, reset PC,
// FSM encodings and the {pc, instr} payload carried through the fetch buffer.
package fetch_stage_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = 2;

    localparam logic [WORD_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam logic [0:0] ST_FETCH   = 1'b0;
    localparam logic [0:0] ST_DISCARD = 1'b1;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic logic [WORD_WIDTH-1:0] align_word(input logic [WORD_WIDTH-1:0] addr);
        return addr & ~WORD_WIDTH'(3);
    endfunction

    // Sequential fetch address; wraps naturally at 2^32.
    function automatic logic [WORD_WIDTH-1:0] next_pc(input logic [WORD_WIDTH-1:0] pc);
        return pc + WORD_WIDTH'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer. The head slot is only overwritten by real data, so
// it keeps showing the last instruction once the buffer drains or is flushed.
module fetch_fifo
    import fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  fetch_entry_t       wdata_i,
    output fetch_entry_t       head_o,
    output logic [CNT_W-1:0]   count_o
);

    fetch_entry_t     head_q, head_d;
    fetch_entry_t     tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q < CNT_W'(FIFO_DEPTH)) || do_pop);

        if (flush_i) begin
            count_d = '0;
        end else if (do_pop && (count_q == CNT_W'(2))) begin
            head_d = tail_q;
            if (do_push) begin
                tail_d = wdata_i;
            end else begin
                count_d = CNT_W'(1);
            end
        end else if (do_pop) begin
            // Single entry popped: a simultaneous push becomes the new head.
            if (do_push) begin
                head_d = wdata_i;
            end else begin
                count_d = '0;
            end
        end else if (do_push) begin
            if (count_q == '0) begin
                head_d = wdata_i;
            end else begin
                tail_d = wdata_i;
            end
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word fetches, buffers up to two fetched
// instructions for ID, and squashes in-flight work on a resolved redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned           BUF_DEPTH = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imemReq,
    output logic [WORD_WIDTH-1:0] imemAddr,
    input  logic                  imemAck,
    input  logic [WORD_WIDTH-1:0] imemRdata,
    input  logic                  stallD,
    input  logic                  redirect,
    input  logic [WORD_WIDTH-1:0] redirectPc,
    output logic [WORD_WIDTH-1:0] pcF,
    output logic [WORD_WIDTH-1:0] instrD,
    output logic [WORD_WIDTH-1:0] pcD,
    output logic                  validD
);

    logic [0:0]            state_q, state_d;
    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    logic [WORD_WIDTH-1:0] squash_addr_q, squash_addr_d;

    logic                  req_c;
    logic                  ack_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  flush_c;
    fetch_entry_t          wdata;
    fetch_entry_t          head;
    logic [CNT_W-1:0]      count;

    // Memory answers in the request cycle, so a request is only issued when
    // the buffer has room for its data right now.
    assign req_c = (state_q == ST_DISCARD) || (count < CNT_W'(BUF_DEPTH));
    assign ack_c = req_c && imemAck;
    assign wdata = '{pc: pc_q, instr: imemRdata};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        squash_addr_d = squash_addr_q;
        push_c        = 1'b0;
        pop_c         = 1'b0;
        flush_c       = 1'b0;

        if (state_q == ST_DISCARD) begin
            // Squashed request must still complete at its original address.
            if (redirect) begin
                pc_d = align_word(redirectPc);
            end
            if (imemAck) begin
                state_d = ST_FETCH;
            end
        end else begin
            if (redirect) begin
                flush_c = 1'b1;
                pc_d    = align_word(redirectPc);
                if (req_c && !imemAck) begin
                    state_d       = ST_DISCARD;
                    squash_addr_d = pc_q;
                end
            end else begin
                pop_c = validD && !stallD;
                if (ack_c) begin
                    push_c = 1'b1;
                    pc_d   = next_pc(pc_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            squash_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            squash_addr_q <= squash_addr_d;
        end
    end

    fetch_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .flush_i (flush_c),
        .wdata_i (wdata),
        .head_o  (head),
        .count_o (count)
    );

    assign imemReq  = req_c && !rst;
    assign imemAddr = (state_q == ST_DISCARD) ? squash_addr_q : pc_q;
    assign pcF      = pc_q;
    assign validD   = (count != '0);
    assign instrD   = head.instr;
    assign pcD      = head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a zero-wait instruction memory whose
// data word is a fixed function of the fetch address.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic        stallD;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [31:0] pcF;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic        validD;

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemAck    (imemAck),
        .imemRdata  (imemRdata),
        .stallD     (stallD),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .pcF        (pcF),
        .instrD     (instrD),
        .pcD        (pcD),
        .validD     (validD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    assign imemRdata = mem_word(imemAddr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imemAck = 1'b0; stallD = 1'b0; redirect = 1'b0; redirectPc = '0;
        tick(); tick();

        // Reset values
        check_eq("rst_req",    32'(imemReq), 32'd0);
        check_eq("rst_valid",  32'(validD),  32'd0);
        check_eq("rst_pcF",    pcF,          32'h0000_3000);
        check_eq("rst_pcD",    pcD,          32'h0);
        check_eq("rst_instrD", instrD,       32'h0);

        // Streaming with ack tied high
        rst = 1'b0; imemAck = 1'b1;
        #1;
        check_eq("first_req",   32'(imemReq), 32'd1);
        check_eq("first_addr",  imemAddr,     32'h0000_3000);
        check_eq("first_valid", 32'(validD),  32'd0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            check_eq("stream_addr",  imemAddr,    32'h0000_3000 + 32'(4 * k));
            check_eq("stream_valid", 32'(validD), 32'd1);
            check_eq("stream_pcD",   pcD,         32'h0000_3000 + 32'(4 * (k - 1)));
            check_eq("stream_instr", instrD,      mem_word(32'h0000_3000 + 32'(4 * (k - 1))));
            tick();
        end

        // Stall fills the buffer and blocks requests
        stallD = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("stall_req",   32'(imemReq), 32'd0);
            check_eq("stall_pcD",   pcD,          32'h0000_3010);
            check_eq("stall_instr", instrD,       mem_word(32'h0000_3010));
            check_eq("stall_addr",  imemAddr,     32'h0000_3018);
            tick();
        end
        stallD = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_eq("release_valid", 32'(validD), 32'd1);
            check_eq("release_pcD",   pcD,         32'h0000_3010 + 32'(4 * k));
        end
        check_eq("release_addr", imemAddr, 32'h0000_3020);

        // Redirect while request outstanding, ack delayed
        imemAck = 1'b0; redirect = 1'b1; redirectPc = 32'h0000_4001;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("disc_req",   32'(imemReq), 32'd1);
            check_eq("disc_addr",  imemAddr,     32'h0000_3020);
            check_eq("disc_pcF",   pcF,          32'h0000_4000);
            check_eq("disc_valid", 32'(validD),  32'd0);
            if (i < 2) tick();
        end
        imemAck = 1'b1;
        tick();
        check_eq("disc_drop_valid", 32'(validD), 32'd0);
        check_eq("disc_new_req",    32'(imemReq), 32'd1);
        check_eq("disc_new_addr",   imemAddr,    32'h0000_4000);
        tick();
        check_eq("disc_first_valid", 32'(validD), 32'd1);
        check_eq("disc_first_pcD",   pcD,         32'h0000_4000);
        check_eq("disc_first_instr", instrD,      mem_word(32'h0000_4000));

        // Redirect with full buffer while ack is high
        stallD = 1'b1;
        tick();
        check_eq("full_req", 32'(imemReq), 32'd0);
        redirect = 1'b1; redirectPc = 32'h0000_5000;
        tick();
        redirect = 1'b0; stallD = 1'b0;
        check_eq("full_redir_valid", 32'(validD), 32'd0);
        check_eq("full_redir_addr",  imemAddr,    32'h0000_5000);
        check_eq("full_redir_req",   32'(imemReq), 32'd1);
        check_eq("full_redir_hold",  pcD,         32'h0000_4000);
        tick();
        check_eq("full_redir_pcD",   pcD,         32'h0000_5000);
        check_eq("full_redir_v2",    32'(validD), 32'd1);

        // Redirect coincident with an accepted ack
        redirect = 1'b1; redirectPc = 32'h0000_6008;
        tick();
        redirect = 1'b0;
        check_eq("ackredir_valid", 32'(validD), 32'd0);
        check_eq("ackredir_hold",  pcD,         32'h0000_5000);
        check_eq("ackredir_addr",  imemAddr,    32'h0000_6008);
        tick();
        check_eq("ackredir_pcD",   pcD,         32'h0000_6008);
        check_eq("ackredir_addr2", imemAddr,    32'h0000_600C);

        // PC wrap at top of address space
        redirect = 1'b1; redirectPc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        check_eq("wrap_addr0", imemAddr, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_addr1", imemAddr, 32'h0000_0000);
        check_eq("wrap_pcD",   pcD,      32'hFFFF_FFFC);
        check_eq("wrap_instr", instrD,   32'h5A5A_FFFC);
        tick();
        check_eq("wrap_pcD2",  pcD,      32'h0000_0000);
        check_eq("wrap_addr2", imemAddr, 32'h0000_0004);

        // Reset with a full buffer
        stallD = 1'b1;
        tick();
        check_eq("prerst_req",   32'(imemReq), 32'd0);
        check_eq("prerst_valid", 32'(validD),  32'd1);
        rst = 1'b1;
        tick();
        check_eq("midrst_valid", 32'(validD),  32'd0);
        check_eq("midrst_req",   32'(imemReq), 32'd0);
        check_eq("midrst_pcF",   pcF,          32'h0000_3000);
        check_eq("midrst_pcD",   pcD,          32'h0);
        rst = 1'b0; stallD = 1'b0;
        #1;
        check_eq("postrst_req",  32'(imemReq), 32'd1);
        check_eq("postrst_addr", imemAddr,     32'h0000_3000);
        tick();
        check_eq("postrst_pcD",  pcD,          32'h0000_3000);
        check_eq("postrst_valid", 32'(validD), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
